gate_reciprocal_counter: RTL
============================

Name: gate_reciprocal_counter

Overview:
- Equal-precision (reciprocal) counting stage downstream of the clock divider.
- Consumes the divider's clk_div output as the preset gate. Aligns the actual gate to rising edges of the measured signal.
- During the actual gate, counts measured-signal periods (Nx) and reference clock cycles (Ns). Presents both with a valid pulse to the frequency-computation stage: f = Nx * f_clk / Ns.

Parameters:
- CNT_WIDTH, 32, width of the Nx and Ns counters and result registers.
- TIMEOUT_CYCLES, 32'd100_000_000, clk cycles allowed in a wait-for-signal-edge state before aborting.

Ports:
- clk  input  1  reference clock; also clocks the upstream divider.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable, synchronous to clk. Low forces IDLE.
- gate  input  1  preset gate (divider clk_div), synchronous to clk.
- sig_in  input  1  measured signal, asynchronous to clk.
- nx_out  output  CNT_WIDTH  latched signal-period count.
- ns_out  output  CNT_WIDTH  latched reference-cycle count.
- meas_valid  output  1  one-cycle pulse when nx_out/ns_out/meas_err/meas_ovf update.
- meas_err  output  1  latched with results: 1 = no signal edge (abort/timeout); counts are zero.
- meas_ovf  output  1  latched with results: 1 = a counter saturated.
- busy  output  1  high in OPEN_WAIT, MEASURE, CLOSE_WAIT.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, all counters 0, synchronizer flops 0, state IDLE.
- Signal edge detection:
  - sig_in passes through a 2-FF synchronizer s1→s2, then s3 <= s2.
  - sig_rise = s2 & ~s3. A sig_in rising edge produces sig_rise 2-3 clk later.
- Gate edge detection: gate_d <= gate; gate_rise = gate & ~gate_d; gate_fall = ~gate & gate_d.
- State machine:
  - IDLE: wait en=1 and gate=0, then go WAIT_GATE. Never start mid-gate.
  - WAIT_GATE: on gate_rise, go OPEN_WAIT; clear wait_cnt.
  - OPEN_WAIT:
    - On sig_rise: nx<=0, ns<=0, go MEASURE.
    - Else if gate_fall or wait_cnt==TIMEOUT_CYCLES-1: abort to REPORT with err=1.
    - Else wait_cnt++.
  - MEASURE:
    - ns++ every cycle; nx++ on each sig_rise.
    - On gate_fall: go CLOSE_WAIT; clear wait_cnt.
    - sig_rise coincident with gate_fall is counted; no close occurs in that cycle.
  - CLOSE_WAIT:
    - ns++ every cycle; wait_cnt++.
    - On sig_rise: nx++ (final), go REPORT with err=0.
    - If wait_cnt==TIMEOUT_CYCLES-1 first: go REPORT with err=1.
  - REPORT (1 cycle):
    - nx_out/ns_out <= final counts, or 0 if err.
    - meas_err <= err; meas_ovf <= ovf flag; meas_valid=1; clear ovf.
    - Next state: WAIT_GATE if en, else IDLE.
- Count relationship: Ns equals the clk cycles between the opening and closing sig_rise cycles. Nx equals the sig periods in that span, always ≥1 on success.
- Saturation: nx/ns stop at all-ones and set ovf. Measurement still completes normally.
- en deasserted in any state except REPORT: go IDLE immediately, no report, counters cleared. Outputs keep their last latched values.
- Gate rising edges arriving while not in WAIT_GATE are ignored. The next measurement uses the next full gate.
- Output registers hold their values between reports. meas_valid is high only in the REPORT cycle.

Decomposition:
- Shared package: state encoding (IDLE, WAIT_GATE, OPEN_WAIT, MEASURE, CLOSE_WAIT, REPORT) and CNT_WIDTH default.
- One natural sub-module, sig_sync_edge: 2-FF synchronizer plus rising-edge detector, with clk/rst_n. Reused for other asynchronous inputs in the meter.

Test Plan:
- Basic measurement:
  - Stimulus: en=1; gate high 100 clk; sig period 10 clk, first sig_rise 3 clk after gate_rise.
  - Response: one meas_valid; nx_out=10, ns_out=100, meas_err=0, meas_ovf=0.
- Non-integer ratio:
  - Stimulus: sig period 7 clk; gate high 100 clk, opening 2 clk after gate_rise.
  - Response: closes on first sig_rise after gate_fall; nx_out=15, ns_out=105.
- No signal:
  - Stimulus: sig_in held 0 through a full gate.
  - Response: at gate_fall, meas_valid with meas_err=1, nx_out=0, ns_out=0.
- Close timeout:
  - Stimulus: TIMEOUT_CYCLES=50; signal stops after the gate opens.
  - Response: meas_err=1 exactly 50 cycles after gate_fall; counts zero.
- Saturation:
  - Stimulus: CNT_WIDTH=8; gate 300 clk; sig period 4.
  - Response: ns_out=255, meas_ovf=1, nx_out=75 (period count still exact).
- Reset and enable abort:
  - Stimulus: rst_n low mid-MEASURE, then en low mid-MEASURE.
  - Response: all outputs 0 immediately on rst_n low. With en low, no meas_valid; previous results held; busy=0 next cycle.

Source files
------------

// File: rtl/gate_reciprocal_counter_pkg.sv
// Shared state encoding and default widths for the reciprocal (equal-precision) counter.
package gate_reciprocal_counter_pkg;

  localparam int CNT_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_GATE  = 3'd1,
    ST_OPEN_WAIT  = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_CLOSE_WAIT = 3'd4,
    ST_REPORT     = 3'd5
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_OPEN_WAIT) || (s == ST_MEASURE) || (s == ST_CLOSE_WAIT);
  endfunction

endpackage

// File: rtl/gate_reciprocal_counter_sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, followed by a rising-edge detector.
// Latency: a rising edge on async_in shows up as a one-cycle rise pulse 2-3 clk later.
// Backpressure: none; pulses are produced unconditionally.
module gate_reciprocal_counter_sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/gate_reciprocal_counter.sv
// Reciprocal frequency counter: aligns the preset gate to sig_in rising edges, counts Nx/Ns.
// Latency: results and meas_valid appear the cycle after the closing sig_rise (or abort).
// Backpressure: none; the consumer must capture nx_out/ns_out on the meas_valid pulse.
module gate_reciprocal_counter
  import gate_reciprocal_counter_pkg::*;
#(
  parameter int          CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 gate,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] nx_out,
  output logic [CNT_WIDTH-1:0] ns_out,
  output logic                 meas_valid,
  output logic                 meas_err,
  output logic                 meas_ovf,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic                 gate_prev_q;
  logic [CNT_WIDTH-1:0] nx_q, nx_d, ns_q, ns_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0] nx_out_q, nx_out_d, ns_out_q, ns_out_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 meas_err_q, meas_err_d;
  logic                 meas_ovf_q, meas_ovf_d;

  logic                 sig_rise, gate_rise, gate_fall;
  logic                 nx_sat, ns_sat, wait_last;
  logic [CNT_WIDTH-1:0] nx_inc, ns_inc;
  logic                 load, load_err;

  gate_reciprocal_counter_sig_sync_edge u_sig_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sig_in),
    .rise     (sig_rise)
  );

  assign gate_rise = gate & ~gate_prev_q;
  assign gate_fall = ~gate & gate_prev_q;
  assign nx_sat    = &nx_q;
  assign ns_sat    = &ns_q;
  assign nx_inc    = nx_sat ? nx_q : nx_q + CNT_WIDTH'(1);
  assign ns_inc    = ns_sat ? ns_q : ns_q + CNT_WIDTH'(1);
  assign wait_last = (wait_cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    state_d      = state_q;
    nx_d         = nx_q;
    ns_d         = ns_q;
    ovf_d        = ovf_q;
    wait_cnt_d   = wait_cnt_q;
    nx_out_d     = nx_out_q;
    ns_out_d     = ns_out_q;
    meas_err_d   = meas_err_q;
    meas_ovf_d   = meas_ovf_q;
    meas_valid_d = 1'b0;
    load         = 1'b0;
    load_err     = 1'b0;

    case (state_q)
      ST_IDLE: if (en && !gate) state_d = ST_WAIT_GATE;
      ST_WAIT_GATE: if (gate_rise) begin
        state_d    = ST_OPEN_WAIT;
        wait_cnt_d = '0;
      end
      ST_OPEN_WAIT: begin
        if (sig_rise) begin
          nx_d    = '0;
          ns_d    = '0;
          ovf_d   = 1'b0;
          state_d = ST_MEASURE;
        end else if (gate_fall || wait_last) begin
          load     = 1'b1;
          load_err = 1'b1;
          state_d  = ST_REPORT;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      ST_MEASURE: begin
        // An edge landing with gate_fall is an interior period, not the closing edge.
        ns_d  = ns_inc;
        ovf_d = ovf_q | ns_sat | (sig_rise & nx_sat);
        if (sig_rise) nx_d = nx_inc;
        if (gate_fall) begin
          state_d    = ST_CLOSE_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_CLOSE_WAIT: begin
        ns_d       = ns_inc;
        ovf_d      = ovf_q | ns_sat;
        wait_cnt_d = wait_cnt_q + 32'd1;
        if (sig_rise) begin
          nx_d    = nx_inc;
          ovf_d   = ovf_q | ns_sat | nx_sat;
          load    = 1'b1;
          state_d = ST_REPORT;
        end else if (wait_last) begin
          load     = 1'b1;
          load_err = 1'b1;
          state_d  = ST_REPORT;
        end
      end
      ST_REPORT: begin
        nx_d    = '0;
        ns_d    = '0;
        ovf_d   = 1'b0;
        state_d = en ? ST_WAIT_GATE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!en && state_q != ST_REPORT) begin
      state_d    = ST_IDLE;
      nx_d       = '0;
      ns_d       = '0;
      ovf_d      = 1'b0;
      wait_cnt_d = '0;
      load       = 1'b0;
    end

    // Results are latched on entry so meas_valid coincides with the REPORT cycle.
    if (load) begin
      meas_valid_d = 1'b1;
      meas_err_d   = load_err;
      meas_ovf_d   = ovf_d;
      nx_out_d     = load_err ? '0 : nx_d;
      ns_out_d     = load_err ? '0 : ns_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gate_prev_q  <= 1'b0;
      nx_q         <= '0;
      ns_q         <= '0;
      ovf_q        <= 1'b0;
      wait_cnt_q   <= '0;
      nx_out_q     <= '0;
      ns_out_q     <= '0;
      meas_valid_q <= 1'b0;
      meas_err_q   <= 1'b0;
      meas_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_prev_q  <= gate;
      nx_q         <= nx_d;
      ns_q         <= ns_d;
      ovf_q        <= ovf_d;
      wait_cnt_q   <= wait_cnt_d;
      nx_out_q     <= nx_out_d;
      ns_out_q     <= ns_out_d;
      meas_valid_q <= meas_valid_d;
      meas_err_q   <= meas_err_d;
      meas_ovf_q   <= meas_ovf_d;
    end
  end

  assign nx_out     = nx_out_q;
  assign ns_out     = ns_out_q;
  assign meas_valid = meas_valid_q;
  assign meas_err   = meas_err_q;
  assign meas_ovf   = meas_ovf_q;
  assign busy       = state_is_busy(state_q);

endmodule
